// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a word-addressed 64-bit RAM, independent read/write FSMs.
// Define AXI_SLV_ERR_EN to enable address range checking and burst-length errors.
module axi4_sram_slave #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [63:0] mem [DEPTH];

  function automatic logic [AW-1:0] widx(input logic [ADDR_W-1:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    unique case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

`ifdef AXI_SLV_ERR_EN
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH) << 3;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  function automatic logic [63:0] rd_word(input logic [ADDR_W-1:0] a);
    return in_range(a) ? mem[widx(a)] : 64'd0;
  endfunction

  function automatic logic [1:0] rd_resp(input logic [ADDR_W-1:0] a);
    return in_range(a) ? 2'b00 : 2'b11;
  endfunction
`else
  function automatic logic [63:0] rd_word(input logic [ADDR_W-1:0] a);
    return mem[widx(a)];
  endfunction

  function automatic logic [1:0] rd_resp(input logic [ADDR_W-1:0] a);
    return (a == a) ? 2'b00 : 2'b11;
  endfunction
`endif

  // Write channel state
  wstate_e           wstate_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [ID_W-1:0]   wid_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wlen_q;
  logic [2:0]        wsize_q;
  logic [1:0]        wburst_q;
  logic              wr_en;

`ifdef AXI_SLV_ERR_EN
  logic [8:0] wcnt_q;
  logic       wdec_q;
  logic       wdec_d;
  logic [1:0] bresp_d;

  always_comb begin
    wdec_d = wdec_q | ~in_range(waddr_q);
    bresp_d = 2'b00;
    if (wdec_d) bresp_d = 2'b11;
    else if (wcnt_q != {1'b0, wlen_q}) bresp_d = 2'b10;
  end

  assign wr_en = wready_q && wvalid && !reset && in_range(waddr_q);
`else
  assign wr_en = wready_q && wvalid && !reset;
`endif

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[widx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
`ifdef AXI_SLV_ERR_EN
      wcnt_q    <= '0;
      wdec_q    <= 1'b0;
`endif
    end else begin
      unique case (wstate_q)
        W_IDLE: begin
          if (awready_q && awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wid_q     <= awid;
            waddr_q   <= awaddr;
            wlen_q    <= awlen;
            wsize_q   <= awsize;
            wburst_q  <= awburst;
`ifdef AXI_SLV_ERR_EN
            wcnt_q    <= '0;
            wdec_q    <= 1'b0;
`endif
            wstate_q  <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
`ifdef AXI_SLV_ERR_EN
            wcnt_q  <= wcnt_q + 9'd1;
            wdec_q  <= wdec_d;
`endif
            if (wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_q;
`ifdef AXI_SLV_ERR_EN
              bresp_q  <= bresp_d;
`else
              bresp_q  <= 2'b00;
`endif
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read channel state
  rstate_e           rstate_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [63:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [7:0]        rlen_q;
  logic [2:0]        rsize_q;
  logic [1:0]        rburst_q;
  logic [7:0]        rcnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
    end else if (rstate_q == R_IDLE) begin
      if (arready_q && arvalid) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rid_q     <= arid;
        rdata_q   <= rd_word(araddr);
        rresp_q   <= rd_resp(araddr);
        rlast_q   <= (arlen == 8'd0);
        rcnt_q    <= '0;
        raddr_q   <= next_addr(araddr, arlen, arsize, arburst);
        rlen_q    <= arlen;
        rsize_q   <= arsize;
        rburst_q  <= arburst;
        rstate_q  <= R_DATA;
      end else begin
        arready_q <= 1'b1;
      end
    end else if (rready) begin
      // Beat just accepted: either close the burst or present the next beat
      if (rlast_q) begin
        rvalid_q  <= 1'b0;
        rlast_q   <= 1'b0;
        arready_q <= 1'b1;
        rstate_q  <= R_IDLE;
      end else begin
        rdata_q <= rd_word(raddr_q);
        rresp_q <= rd_resp(raddr_q);
        rlast_q <= (rcnt_q + 8'd1 == rlen_q);
        rcnt_q  <= rcnt_q + 8'd1;
        raddr_q <= next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule
